vend_dispense_ctrl: RTL
=======================

// Module: vend_dispense_ctrl
// PURPOSE
//  Sequencer between the refrigerante vending FSM and its physical actuators.
//  Latches the FSM's one-cycle sale result (dispense flag + change code), then runs the product motor
//  and pays change from a 5c coin hopper over a 4-phase req/ack handshake.
//  Gates coin input to the FSM while a sale is being serviced; detects hopper timeouts.
// PARAMETERS
//  MOTOR_CYCLES  8   cycles motor_on stays high per dispense (>=1)
//  ACK_TIMEOUT   16  max cycles waiting on any hopper_ack edge before FAULT (>=2)
// PORTS
//  clk         in   1  clock, rising edge
//  rst         in   1  asynchronous, active-high reset
//  moeda_in    in   2  coin slot code: 00 none, 01 5c, 10 10c, 11 25c
//  moeda_out   out  2  coin code forwarded to vending FSM
//  coin_reject out  1  nonzero coin arrived while busy; coin is dropped
//  sale_d      in   1  FSM dispense flag, one-cycle
//  sale_t      in   2  FSM change code: 00 none, 01 5c, 10 10c, 11 20c
//  motor_on    out  1  product motor drive
//  hopper_req  out  1  request one 5c coin from hopper
//  hopper_ack  in   1  hopper acknowledge (4-phase)
//  busy        out  1  sale in progress or fault; coins blocked
//  fault       out  1  hopper timeout; sticky until fault_clr
//  fault_clr   in   1  clears FAULT, returns to IDLE
//  overrun     out  1  sticky: sale event arrived while not IDLE (cleared by fault_clr or rst)
// BEHAVIOUR
//  Reset (async): state=IDLE; motor_on, hopper_req, fault, overrun, coin_reject = 0; counters = 0.
//  moeda_out = busy ? 2'b00 : moeda_in (combinational).
//  coin_reject = busy && moeda_in != 00 (combinational).
//  busy = (state != IDLE), registered from state.
//  Change-coin count latched on sale: t=00->0, 01->1, 10->2, 11->4 (3-bit counter).
//  IDLE: when sale_d || sale_t != 00, latch d/count at that edge.
//   d=1 -> MOTOR; else -> PAY_REQ.
//   Otherwise stay in IDLE.
//  MOTOR: motor_on=1 for exactly MOTOR_CYCLES cycles, starting the cycle after the latch edge.
//   Then -> PAY_REQ if count>0, else IDLE.
//  PAY_REQ: hopper_req=1; wait for hopper_ack=1.
//   On ack -> PAY_REL (req drops the next cycle).
//  PAY_REL: hopper_req=0; wait for hopper_ack=0.
//   On low: count -= 1; -> PAY_REQ if new count>0, else IDLE.
//  Timeout counter clears on entry to PAY_REQ/PAY_REL.
//   Reaching ACK_TIMEOUT cycles without the awaited ack level -> FAULT.
//  FAULT: hopper_req=0, motor_on=0, fault=1, busy=1.
//   fault_clr=1 -> IDLE next cycle; remaining coin count is discarded.
//  Sale event while state != IDLE: ignored; overrun set.
//  fault_clr outside FAULT only clears overrun.
//  Simultaneous sale and fault_clr in FAULT: the sale is ignored and overrun is set.
//  hopper_ack high while in IDLE or MOTOR: ignored.
//  Sale with d=0, t=00 is not an event.
//  rst mid-operation: motor and req drop immediately (async); the pending sale is lost.
// TESTING
//  1. sale_d=1, sale_t=00 one cycle -> motor_on high exactly 8 cycles; busy 8 cycles; then IDLE, no hopper_req.
//  2. sale_d=1, sale_t=01; hopper acks 2 cycles after req -> motor 8 cycles, then exactly one req/ack cycle; IDLE.
//  3. sale_d=0, sale_t=11 (bad-coin refund) -> four complete req/ack handshakes, no motor; busy clears after 4th ack low.
//  4. moeda_in=10 while busy -> moeda_out=00, coin_reject=1; moeda_in=10 in IDLE -> moeda_out=10.
//  5. hopper_ack held 0 after req -> FAULT after 16 cycles: fault=1, req=0; fault_clr -> IDLE, fault=0.
//  6. Assert rst mid-MOTOR -> motor_on=0 same cycle; after release state IDLE, busy=0.

Source files
------------

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: latches a one-cycle sale result, runs the product motor, then pays change
// one 5c coin at a time over a 4-phase req/ack hopper handshake, with timeout to a sticky fault.
module vend_dispense_ctrl #(
  parameter int MOTOR_CYCLES = 8,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] moeda_in,
  output logic [1:0] moeda_out,
  output logic       coin_reject,
  input  logic       sale_d,
  input  logic [1:0] sale_t,
  output logic       motor_on,
  output logic       hopper_req,
  input  logic       hopper_ack,
  output logic       busy,
  output logic       fault,
  input  logic       fault_clr,
  output logic       overrun,
  output logic [2:0] state_dbg
);

  localparam int TMR_MAX = (MOTOR_CYCLES > ACK_TIMEOUT) ? MOTOR_CYCLES : ACK_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] MOT_LAST = TMR_W'(MOTOR_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOTOR   = 3'd1,
    PAY_REQ = 3'd2,
    PAY_REL = 3'd3,
    FAULT   = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [2:0]         coin_cnt, coin_cnt_nx;
  logic [TMR_W-1:0]   tmr, tmr_nx;
  logic               overrun_nx;
  logic               sale_ev;

  // Change code 11 is 20c, i.e. four 5c coins, not three.
  function automatic logic [2:0] change_coins(input logic [1:0] t);
    case (t)
      2'b01:   change_coins = 3'd1;
      2'b10:   change_coins = 3'd2;
      2'b11:   change_coins = 3'd4;
      default: change_coins = 3'd0;
    endcase
  endfunction

  assign sale_ev = sale_d || (sale_t != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      coin_cnt <= '0;
      tmr      <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nx;
      coin_cnt <= coin_cnt_nx;
      tmr      <= tmr_nx;
      overrun  <= overrun_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    coin_cnt_nx = coin_cnt;
    case (state)
      IDLE: begin
        if (sale_ev) begin
          coin_cnt_nx = change_coins(sale_t);
          state_nx    = sale_d ? MOTOR : PAY_REQ;
        end
      end
      MOTOR: begin
        if (tmr == MOT_LAST) state_nx = (coin_cnt != 3'd0) ? PAY_REQ : IDLE;
      end
      PAY_REQ: begin
        if (hopper_ack)          state_nx = PAY_REL;
        else if (tmr == TO_LAST) state_nx = FAULT;
      end
      PAY_REL: begin
        if (!hopper_ack) begin
          coin_cnt_nx = coin_cnt - 3'd1;
          state_nx    = (coin_cnt != 3'd1) ? PAY_REQ : IDLE;
        end else if (tmr == TO_LAST) begin
          state_nx = FAULT;
        end
      end
      FAULT: begin
        if (fault_clr) begin
          state_nx    = IDLE;
          coin_cnt_nx = '0;
        end
      end
      default: begin
        state_nx    = IDLE;
        coin_cnt_nx = '0;
      end
    endcase

    // One shared cycle timer: restarts on every state entry, so PAY_REL->PAY_REQ gets a fresh timeout.
    if ((state_nx != state) || (state == IDLE) || (state == FAULT)) tmr_nx = '0;
    else                                                            tmr_nx = tmr + 1'b1;

    // A sale arriving while busy wins over a simultaneous clear.
    if (sale_ev && (state != IDLE)) overrun_nx = 1'b1;
    else if (fault_clr)             overrun_nx = 1'b0;
    else                            overrun_nx = overrun;
  end

  assign busy        = (state != IDLE);
  assign motor_on    = (state == MOTOR);
  assign hopper_req  = (state == PAY_REQ);
  assign fault       = (state == FAULT);
  assign moeda_out   = busy ? 2'b00 : moeda_in;
  assign coin_reject = busy && (moeda_in != 2'b00);
  assign state_dbg   = state;

endmodule
